// File: rtl/ddr4_cmd_scheduler.sv
// ddr4_cmd_scheduler: single-request DDR4 command sequencer.
// Tracks the open row of every bank and issues PRE/ACT/RD/WR on registered
// command pins. It honours tRP, tRCD, tRAS and tCCD spacing and freezes
// issuing while the emulator's cache-sync stall is high.
module ddr4_cmd_scheduler #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int TRP       = 4,
  parameter int TRCD      = 4,
  parameter int TRAS      = 10,
  parameter int TCCD      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [BGWIDTH-1:0]   req_bg,
  input  logic [BAWIDTH-1:0]   req_ba,
  input  logic [ADDRWIDTH-1:0] req_row,
  input  logic [COLWIDTH-1:0]  req_col,
  output logic                 act_n,
  output logic                 cs_n,
  output logic [ADDRWIDTH-1:0] A,
  output logic [BGWIDTH-1:0]   bg,
  output logic [BAWIDTH-1:0]   ba,
  output logic                 rd_issued,
  output logic                 wr_issued
);

  localparam int BANKW = BGWIDTH + BAWIDTH;
  localparam int NBANK = 1 << BANKW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_ACT  = 2'd2;
  localparam logic [1:0] S_CAS  = 2'd3;

  // Counters hold N-1 after a load so the gated command lands exactly N
  // cycles after the command that loaded them.
  localparam logic [4:0] TRP_LD  = 5'(TRP - 1);
  localparam logic [4:0] TRCD_LD = 5'(TRCD - 1);
  localparam logic [4:0] TRAS_LD = 5'(TRAS - 1);
  localparam logic [4:0] TCCD_LD = 5'(TCCD - 1);

  logic [1:0]           state;

  // Request latched at accept time.
  logic                 wr_q;
  logic [BGWIDTH-1:0]   bg_q;
  logic [BAWIDTH-1:0]   ba_q;
  logic [ADDRWIDTH-1:0] row_q;
  logic [COLWIDTH-1:0]  col_q;

  // Per-bank open-row table and timing counters.
  logic                 open_tab [NBANK];
  logic [ADDRWIDTH-1:0] row_tab  [NBANK];
  logic [4:0]           trp_cnt  [NBANK];
  logic [4:0]           trcd_cnt [NBANK];
  logic [4:0]           tras_cnt [NBANK];
  logic [4:0]           tccd_cnt;

  logic [BANKW-1:0]     cur_bank;
  logic [BANKW-1:0]     req_bank;
  logic                 accept;
  logic                 issue_pre;
  logic                 issue_act;
  logic                 issue_cas;

  logic                 nxt_cs_n;
  logic                 nxt_act_n;
  logic [ADDRWIDTH-1:0] nxt_a;
  logic [BGWIDTH-1:0]   nxt_bg;
  logic [BAWIDTH-1:0]   nxt_ba;

  assign cur_bank  = {bg_q, ba_q};
  assign req_bank  = {req_bg, req_ba};
  assign req_ready = (state == S_IDLE) && !stall;
  assign accept    = req_valid && req_ready;

  assign issue_pre = (state == S_PRE) && !stall &&
                     (tras_cnt[cur_bank] == '0) && open_tab[cur_bank];
  assign issue_act = (state == S_ACT) && !stall && (trp_cnt[cur_bank] == '0);
  assign issue_cas = (state == S_CAS) && !stall &&
                     (trcd_cnt[cur_bank] == '0) && (tccd_cnt == '0);

  // Sequencer: classify the accepted request as hit/closed/miss and walk it
  // through PRE -> ACT -> CAS as each command issues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      wr_q  <= 1'b0;
      bg_q  <= '0;
      ba_q  <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every flop samples the
      // pre-edge values of its neighbours, independent of block ordering.
      case (state)
        S_IDLE: begin
          if (accept) begin
            wr_q  <= req_wr;
            bg_q  <= req_bg;
            ba_q  <= req_ba;
            row_q <= req_row;
            col_q <= req_col;
            if (!open_tab[req_bank])                  state <= S_ACT;
            else if (row_tab[req_bank] == req_row)    state <= S_CAS;
            else                                      state <= S_PRE;
          end
        end
        S_PRE:   if (issue_pre) state <= S_ACT;
        S_ACT:   if (issue_act) state <= S_CAS;
        default: if (issue_cas) state <= S_IDLE;
      endcase
    end
  end

  // Bank table and timing counters; counters keep running through stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the table is a handful of flops, not a RAM, so it is cleared on
      // reset; a reset mid-sequence must forget every open row.
      for (int i = 0; i < NBANK; i++) begin
        open_tab[i] <= 1'b0;
        row_tab[i]  <= '0;
        trp_cnt[i]  <= '0;
        trcd_cnt[i] <= '0;
        tras_cnt[i] <= '0;
      end
      tccd_cnt <= '0;
    end else begin
      for (int i = 0; i < NBANK; i++) begin
        if (issue_pre && cur_bank == BANKW'(i)) begin
          open_tab[i] <= 1'b0;
        end else if (issue_act && cur_bank == BANKW'(i)) begin
          open_tab[i] <= 1'b1;
          row_tab[i]  <= row_q;
        end

        if (issue_pre && cur_bank == BANKW'(i)) trp_cnt[i] <= TRP_LD;
        else if (trp_cnt[i] != '0)              trp_cnt[i] <= trp_cnt[i] - 5'd1;

        if (issue_act && cur_bank == BANKW'(i)) trcd_cnt[i] <= TRCD_LD;
        else if (trcd_cnt[i] != '0)             trcd_cnt[i] <= trcd_cnt[i] - 5'd1;

        if (issue_act && cur_bank == BANKW'(i)) tras_cnt[i] <= TRAS_LD;
        else if (tras_cnt[i] != '0)             tras_cnt[i] <= tras_cnt[i] - 5'd1;
      end

      if (issue_cas)            tccd_cnt <= TCCD_LD;
      else if (tccd_cnt != '0)  tccd_cnt <= tccd_cnt - 5'd1;
    end
  end

  // Next pin values: DES unless one of the issue strobes fires.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    nxt_cs_n  = 1'b1;
    nxt_act_n = 1'b1;
    nxt_a     = '0;
    nxt_bg    = '0;
    nxt_ba    = '0;
    if (issue_pre || issue_act || issue_cas) begin
      nxt_cs_n = 1'b0;
      nxt_bg   = bg_q;
      nxt_ba   = ba_q;
    end
    if (issue_act) begin
      nxt_act_n = 1'b0;
      nxt_a     = row_q;
    end
    if (issue_pre) nxt_a[16:14] = 3'b010;
    if (issue_cas) begin
      nxt_a[16:14]         = wr_q ? 3'b100 : 3'b101;
      nxt_a[COLWIDTH-1:0]  = col_q;
    end
  end

  // Registered command pins and issue pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_n      <= 1'b1;
      act_n     <= 1'b1;
      A         <= '0;
      bg        <= '0;
      ba        <= '0;
      rd_issued <= 1'b0;
      wr_issued <= 1'b0;
    end else begin
      cs_n      <= nxt_cs_n;
      act_n     <= nxt_act_n;
      A         <= nxt_a;
      bg        <= nxt_bg;
      ba        <= nxt_ba;
      rd_issued <= issue_cas && !wr_q;
      wr_issued <= issue_cas && wr_q;
    end
  end

endmodule

// File: tb/tb_ddr4_cmd_scheduler.sv
// Testbench for ddr4_cmd_scheduler: directed scenarios followed by random
// traffic, every pin compared each cycle against a timestamp-based model.
module tb_ddr4_cmd_scheduler;

  localparam int TRP  = 4;
  localparam int TRCD = 4;
  localparam int TRAS = 10;
  localparam int TCCD = 2;
  localparam int NB   = 16;

  localparam int K_PRE = 0;
  localparam int K_ACT = 1;
  localparam int K_RD  = 2;
  localparam int K_WR  = 3;

  localparam logic [24:0] DES = {1'b1, 1'b1, 17'h0, 2'b0, 2'b0, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [1:0]  req_bg = '0;
  logic [1:0]  req_ba = '0;
  logic [16:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic        req_ready;
  logic        act_n;
  logic        cs_n;
  logic [16:0] A;
  logic [1:0]  bg;
  logic [1:0]  ba;
  logic        rd_issued;
  logic        wr_issued;

  ddr4_cmd_scheduler #(
    .BGWIDTH(2), .BAWIDTH(2), .ADDRWIDTH(17), .COLWIDTH(10),
    .TRP(TRP), .TRCD(TRCD), .TRAS(TRAS), .TCCD(TCCD)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
    .act_n(act_n), .cs_n(cs_n), .A(A), .bg(bg), .ba(ba),
    .rd_issued(rd_issued), .wr_issued(wr_issued)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: pending command list plus last-issue timestamps.
  int          pend[$];
  logic [1:0]  m_bg, m_ba;
  logic [16:0] m_row;
  logic [9:0]  m_col;
  int          m_bank;
  bit          m_open [NB];
  logic [16:0] m_orow [NB];
  int          last_act [NB];
  int          last_pre [NB];
  int          last_cas;
  logic [24:0] exp_pins;
  bit          acc_now;

  // Commands observed on the pins.
  int          obs_act_t = -1, obs_pre_t = -1, obs_rd_t = -1, obs_rd_prev = -1, obs_wr_t = -1;
  logic [16:0] obs_act_a = '0;
  int          rd_cnt = 0, wr_cnt = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [24:0] enc(int kind, logic [1:0] g, logic [1:0] b,
                                      logic [16:0] row, logic [9:0] col);
    logic [16:0] a;
    logic        an, r, w;
    a = '0; an = 1'b1; r = 1'b0; w = 1'b0;
    case (kind)
      K_ACT: begin an = 1'b0; a = row; end
      K_PRE: a[16:14] = 3'b010;
      K_RD:  begin a[16:14] = 3'b101; a[9:0] = col; r = 1'b1; end
      default: begin a[16:14] = 3'b100; a[9:0] = col; w = 1'b1; end
    endcase
    return {1'b0, an, a, g, b, r, w};
  endfunction

  function automatic logic [24:0] pins_now();
    return {cs_n, act_n, A, bg, ba, rd_issued, wr_issued};
  endfunction

  task automatic check(string tag, logic [24:0] obs, logic [24:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    pend.delete();
    for (int i = 0; i < NB; i++) begin
      m_open[i] = 1'b0; m_orow[i] = '0; last_act[i] = -1000; last_pre[i] = -1000;
    end
    last_cas = -1000;
  endtask

  // Model of one clock edge: first try to issue the head of the pending list
  // (each command waits until its timing window has elapsed and stall is low),
  // then accept a new request if nothing was pending during the cycle.
  task automatic model_edge();
    bit idle, ok;
    int b;
    exp_pins = DES;
    acc_now  = 1'b0;
    if (reset) begin
      model_clear();
      return;
    end
    idle = (pend.size() == 0);
    b = m_bank;
    if (!idle && !stall) begin
      case (pend[0])
        K_PRE:   ok = (cyc >= last_act[b] + TRAS);
        K_ACT:   ok = (cyc >= last_pre[b] + TRP);
        default: ok = (cyc >= last_act[b] + TRCD) && (cyc >= last_cas + TCCD);
      endcase
      if (ok) begin
        exp_pins = enc(pend[0], m_bg, m_ba, m_row, m_col);
        case (pend[0])
          K_PRE:   begin m_open[b] = 1'b0; last_pre[b] = cyc; end
          K_ACT:   begin m_open[b] = 1'b1; m_orow[b] = m_row; last_act[b] = cyc; end
          default: last_cas = cyc;
        endcase
        void'(pend.pop_front());
      end
    end
    if (idle && !stall && req_valid) begin
      acc_now = 1'b1;
      m_bg = req_bg; m_ba = req_ba; m_row = req_row; m_col = req_col;
      m_bank = {req_bg, req_ba};
      if (m_open[m_bank] && m_orow[m_bank] == req_row) begin
        pend.push_back(req_wr ? K_WR : K_RD);
      end else if (!m_open[m_bank]) begin
        pend.push_back(K_ACT); pend.push_back(req_wr ? K_WR : K_RD);
      end else begin
        pend.push_back(K_PRE); pend.push_back(K_ACT); pend.push_back(req_wr ? K_WR : K_RD);
      end
    end
  endtask

  task automatic observe(logic [24:0] p);
    if (!cs_n) begin
      if (!act_n) begin
        obs_act_t = cyc; obs_act_a = A;
      end else begin
        case (A[16:14])
          3'b010: obs_pre_t = cyc;
          3'b101: begin obs_rd_prev = obs_rd_t; obs_rd_t = cyc; rd_cnt++; end
          3'b100: begin obs_wr_t = cyc; wr_cnt++; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic tick();
    logic [24:0] got;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    got = pins_now();
    observe(got);
    check("pins", got, exp_pins);
  endtask

  // Drive inputs for the next edge, check req_ready, then advance one edge.
  task automatic cycle(bit v, bit w, logic [1:0] g, logic [1:0] b,
                       logic [16:0] r, logic [9:0] c, bit s);
    req_valid = v; req_wr = w; req_bg = g; req_ba = b;
    req_row = r; req_col = c; stall = s;
    #1;
    check("req_ready", 25'(req_ready), 25'((pend.size() == 0) && !stall));
    tick();
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 2'd0, 2'd0, 17'h0, 10'h0, 1'b0);
  endtask

  task automatic request(bit w, logic [1:0] g, logic [1:0] b,
                         logic [16:0] r, logic [9:0] c, output int n);
    n = -1;
    for (int k = 0; k < 100 && n < 0; k++) begin
      cycle(1'b1, w, g, b, r, c, 1'b0);
      if (acc_now) n = cyc;
    end
    check("accept_in_time", 25'(n >= 0), 25'(1));
  endtask

  logic [16:0] rows [3] = '{17'h00010, 17'h00011, 17'h1FFFF};

  initial begin
    int n, n2, a1, p0, a0;
    model_clear();

    // Reset and idle behaviour.
    tick();
    tick();
    check("reset_pins", pins_now(), DES);
    reset = 1'b0;
    idle(20);
    check("no_pulses_idle", 25'(rd_cnt + wr_cnt), 25'(0));

    // WR to a closed bank: ACT at n+1, WR at n+1+TRCD.
    request(1'b1, 2'd1, 2'd2, 17'h155, 10'h020, n);
    idle(8);
    check("wr_act_time", 25'(obs_act_t), 25'(n + 1));
    check("wr_act_row",  25'(obs_act_a), 25'(17'h155));
    check("wr_time",     25'(obs_wr_t),  25'(n + 5));
    check("wr_count",    25'(wr_cnt),    25'(1));

    // Back-to-back row hits: no ACT/PRE, reads exactly TCCD apart.
    a0 = obs_act_t; p0 = obs_pre_t;
    request(1'b0, 2'd1, 2'd2, 17'h155, 10'h000, n);
    request(1'b0, 2'd1, 2'd2, 17'h155, 10'h008, n2);
    idle(4);
    check("hit_rd_count", 25'(rd_cnt), 25'(2));
    check("hit_rd_gap",   25'(obs_rd_t - obs_rd_prev), 25'(TCCD));
    check("hit_no_act",   25'(obs_act_t), 25'(a0));
    check("hit_no_pre",   25'(obs_pre_t), 25'(p0));

    // Row miss accepted 5 cycles after ACT: PRE waits for tRAS.
    request(1'b0, 2'd1, 2'd2, 17'h3C3, 10'h001, n);
    request(1'b0, 2'd1, 2'd2, 17'h2AA, 10'h002, n2);
    a1 = obs_act_t;
    check("miss_accept_time", 25'(n2), 25'(a1 + 5));
    idle(25);
    check("miss_pre_time", 25'(obs_pre_t), 25'(a1 + TRAS));
    check("miss_act_time", 25'(obs_act_t), 25'(a1 + TRAS + TRP));
    check("miss_act_row",  25'(obs_act_a), 25'(17'h2AA));
    check("miss_rd_time",  25'(obs_rd_t),  25'(a1 + TRAS + TRP + TRCD));

    // Stall for 3 cycles while tRCD counter holds 2.
    request(1'b0, 2'd3, 2'd0, 17'h007, 10'h003, n);
    idle(2);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 2'd0, 2'd0, 17'h0, 10'h0, 1'b1);
    idle(3);
    check("stall_act_time", 25'(obs_act_t), 25'(n + 1));
    check("stall_rd_time",  25'(obs_rd_t),  25'(n + 6));

    // Reset two cycles after a PRE, then reuse the bank.
    p0 = obs_pre_t;
    request(1'b0, 2'd3, 2'd0, 17'h008, 10'h000, n);
    for (int k = 0; k < 40 && obs_pre_t == p0; k++) idle(1);
    check("pre_seen", 25'(obs_pre_t != p0), 25'(1));
    idle(2);
    reset = 1'b1;
    model_clear();
    #1;
    check("reset_after_pre_pins", pins_now(), DES);
    idle(2);
    reset = 1'b0;
    idle(2);
    p0 = obs_pre_t;
    request(1'b0, 2'd3, 2'd0, 17'h008, 10'h005, n);
    idle(1);
    check("post_reset_act_time", 25'(obs_act_t), 25'(n + 1));
    check("post_reset_act_row",  25'(obs_act_a), 25'(17'h008));
    // Reset while ACT sits on the pins: must drop to DES without a clock.
    reset = 1'b1;
    model_clear();
    #1;
    check("async_reset_pins", pins_now(), DES);
    idle(2);
    reset = 1'b0;
    idle(3);
    check("post_reset_no_pre", 25'(obs_pre_t), 25'(p0));

    // Random traffic over a few banks and rows, with random stall.
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            rows[$urandom_range(0, 2)], 10'($urandom), ($urandom_range(0, 9) < 2));
    end
    idle(40);
    check("drained", 25'(pend.size()), 25'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
